// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce block.
package debounce_pkg;

  // Stability-filter FSM states.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  // Smallest legal values of the top-level parameters.
  localparam int MIN_STABLE_CYCLES = 2;
  localparam int MIN_SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_sync_cell.sv
// Multi-flop synchronizer for a single asynchronous bit. The stages are
// wired flop-to-flop with nothing in between, so metastability has a full
// cycle to resolve at each stage.
module sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw input through the chain; the last stage is the safe output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: synchronizes a raw bouncy level, then only lets data_o follow
// it once STABLE_CYCLES consecutive identical samples have been seen. Any
// interruption of a qualification run aborts it, restarts from scratch and
// produces a one-cycle glitch pulse.
module debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic data_i,
  output logic data_o,
  output logic busy_o,
  output logic glitch_o
);

  // Counter is wide enough to hold STABLE_CYCLES; in practice it stops at
  // STABLE_CYCLES-1 because the qualifying sample is detected as cnt+1.
  localparam int              CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < MIN_STABLE_CYCLES || SYNC_STAGES < MIN_SYNC_STAGES) begin : g_param_check
    $fatal(1, "debounce: STABLE_CYCLES and SYNC_STAGES must each be at least 2");
  end

  logic             sync_q;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (data_i),
    .q_o  (sync_q)
  );

  // Stability filter: qualify each level change, abort on any contrary sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOW;
      cnt      <= '0;
      data_o   <= 1'b0;
      glitch_o <= 1'b0;
    end else begin
      glitch_o <= 1'b0;
      case (state)
        LOW: begin
          if (sync_q) begin
            state <= RISE_CHK;
            cnt   <= ONE;
          end
        end
        RISE_CHK: begin
          if (!sync_q) begin
            state    <= LOW;
            cnt      <= '0;
            glitch_o <= 1'b1;
          end else if (cnt == LAST) begin
            state  <= HIGH;
            data_o <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HIGH: begin
          if (!sync_q) begin
            state <= FALL_CHK;
            cnt   <= ONE;
          end
        end
        FALL_CHK: begin
          if (sync_q) begin
            state    <= HIGH;
            cnt      <= '0;
            glitch_o <= 1'b1;
          end else if (cnt == LAST) begin
            state  <= LOW;
            data_o <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state  <= LOW;
          cnt    <= '0;
          data_o <= 1'b0;
        end
      endcase
    end
  end

  // Busy whenever a qualification run is in progress.
  assign busy_o = (state == RISE_CHK) || (state == FALL_CHK);

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce: a short-window instance (STABLE_CYCLES=4)
// exercised edge by edge, plus a default-parameter instance for the long
// 999/1000-sample boundary.
module tb_debounce;

  logic clk = 1'b0;
  logic reset;
  logic data;
  logic data_o, busy_o, glitch_o;
  logic data_d;
  logic data_o_d, busy_o_d, glitch_o_d;

  int vectors    = 0;
  int miscompares = 0;
  int max_cnt    = 0;

  always #5 clk = ~clk;

  debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .glitch_o(glitch_o)
  );

  debounce dut_def (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_d),
    .data_o  (data_o_d),
    .busy_o  (busy_o_d),
    .glitch_o(glitch_o_d)
  );

  // Track the largest counter value reached by the default instance.
  always @(posedge clk) begin
    if (int'(dut_def.cnt) > max_cnt) max_cnt <= int'(dut_def.cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {data,busy,glitch}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive data for the next edge, take the edge, then check {data_o,busy_o,glitch_o}.
  task automatic step(input logic din, input logic [2:0] exp, input string tag);
    data = din;
    tick();
    check(tag, {data_o, busy_o, glitch_o}, exp);
  endtask

  initial begin
    reset  = 1'b1;
    data   = 1'b0;
    data_d = 1'b0;
    tick();
    tick();
    check("reset_state", {data_o, busy_o, glitch_o}, 3'b000);
    reset = 1'b0;
    step(0, 3'b000, "idle0");
    step(0, 3'b000, "idle1");

    // Clean rise.
    step(1, 3'b000, "rise_e1");
    step(1, 3'b000, "rise_e2");
    step(1, 3'b010, "rise_e3");
    step(1, 3'b010, "rise_e4");
    step(1, 3'b010, "rise_e5");
    step(1, 3'b100, "rise_e6");
    step(1, 3'b100, "rise_e7");

    // Clean fall back to LOW.
    step(0, 3'b100, "fall_e1");
    step(0, 3'b100, "fall_e2");
    step(0, 3'b110, "fall_e3");
    step(0, 3'b110, "fall_e4");
    step(0, 3'b110, "fall_e5");
    step(0, 3'b000, "fall_e6");
    step(0, 3'b000, "fall_e7");

    // Short bounce: high across edges 1-2 only.
    step(1, 3'b000, "bounce_e1");
    step(1, 3'b000, "bounce_e2");
    step(0, 3'b010, "bounce_e3");
    step(0, 3'b010, "bounce_e4");
    step(0, 3'b001, "bounce_e5");
    step(0, 3'b000, "bounce_e6");
    step(0, 3'b000, "bounce_e7");

    // Boundary: 3 high samples abort.
    step(1, 3'b000, "b3_e1");
    step(1, 3'b000, "b3_e2");
    step(1, 3'b010, "b3_e3");
    step(0, 3'b010, "b3_e4");
    step(0, 3'b010, "b3_e5");
    step(0, 3'b001, "b3_e6");
    step(0, 3'b000, "b3_e7");
    step(0, 3'b000, "b3_idle");

    // Boundary: 4 high samples qualify, then the low level qualifies back.
    step(1, 3'b000, "b4_e1");
    step(1, 3'b000, "b4_e2");
    step(1, 3'b010, "b4_e3");
    step(1, 3'b010, "b4_e4");
    step(0, 3'b010, "b4_e5");
    step(0, 3'b100, "b4_e6");
    step(0, 3'b110, "b4_e7");
    step(0, 3'b110, "b4_e8");
    step(0, 3'b110, "b4_e9");
    step(0, 3'b000, "b4_e10");

    // Get to HIGH, then fall with bounce 0,1,0,1 and hold 0.
    for (int i = 0; i < 8; i++) begin
      data = 1'b1;
      tick();
    end
    check("fb_start_high", {data_o, busy_o, glitch_o}, 3'b100);
    step(0, 3'b100, "fb_e1");
    step(1, 3'b100, "fb_e2");
    step(0, 3'b110, "fb_e3");
    step(1, 3'b101, "fb_e4");
    step(0, 3'b110, "fb_e5");
    step(0, 3'b101, "fb_e6");
    step(0, 3'b110, "fb_e7");
    step(0, 3'b110, "fb_e8");
    step(0, 3'b110, "fb_e9");
    step(0, 3'b000, "fb_e10");
    step(0, 3'b000, "fb_e11");

    // Reset asserted asynchronously in RISE_CHK with cnt=2.
    step(1, 3'b000, "rst_e1");
    step(1, 3'b000, "rst_e2");
    step(1, 3'b010, "rst_e3");
    step(1, 3'b010, "rst_e4");
    reset = 1'b1;
    #2;
    check("rst_async", {data_o, busy_o, glitch_o}, 3'b000);
    tick();
    check("rst_held", {data_o, busy_o, glitch_o}, 3'b000);
    reset = 1'b0;
    step(1, 3'b000, "rst_post_e1");
    step(1, 3'b000, "rst_post_e2");
    step(1, 3'b010, "rst_post_e3");
    step(1, 3'b010, "rst_post_e4");
    step(1, 3'b010, "rst_post_e5");
    step(1, 3'b100, "rst_post_e6");

    // Default parameters: 999-sample burst must not change data_o.
    for (int k = 1; k <= 1004; k++) begin
      data_d = (k <= 999);
      tick();
      if (k == 1001) check("def999_e1001", {data_o_d, busy_o_d, glitch_o_d}, 3'b010);
      if (k == 1002) check("def999_e1002", {data_o_d, busy_o_d, glitch_o_d}, 3'b001);
    end

    // Default parameters: 1000-sample burst flips data_o at edge 1002.
    for (int k = 1; k <= 1002; k++) begin
      data_d = (k <= 1000);
      tick();
      if (k == 1001) check("def1000_e1001", {data_o_d, busy_o_d, glitch_o_d}, 3'b010);
      if (k == 1002) check("def1000_e1002", {data_o_d, busy_o_d, glitch_o_d}, 3'b100);
    end
    tick();
    vectors++;
    assert (max_cnt === 999) else begin
      miscompares++;
      $error("FAIL def_max_cnt: observed %0d expected %0d", max_cnt, 999);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce.md
Name: debounce

Overview:
- Conditions a raw, asynchronous, bouncy level input (button, strap, external status line) into a clean, clock-synchronous level.
- Sits directly upstream of the one-shot edge detector; its data_o drives that block's data_i.
- The downstream pulse is therefore one clean shot per real transition, never one per bounce.
- Two parts: a synchronizer chain, then a stability-filter FSM with a consecutive-sample counter.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer chain; legal values are 2 or more.
- STABLE_CYCLES, 1000, number of consecutive identical synchronized samples required before data_o changes; legal values are 2 or more.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the internal counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock for the whole block.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  1  raw input; asynchronous to clk and may bounce.
- data_o  output  1  debounced level; registered.
- busy_o  output  1  high while a transition is being qualified (FSM in RISE_CHK or FALL_CHK); decoded from the state register.
- glitch_o  output  1  single-cycle registered pulse when a qualification is aborted.

Behaviour:
- Reset values: all synchronizer flops 0, state LOW, counter 0, data_o 0, glitch_o 0, busy_o 0.
- Reset is asynchronous and can assert mid-qualification. It aborts immediately, and glitch_o is not pulsed.
- Synchronizer: sync_q is the last stage of the SYNC_STAGES-deep chain. No logic sits between stages.
- FSM states:
  - LOW: data_o=0. If sync_q=1, go to RISE_CHK with cnt<=1.
  - RISE_CHK: data_o=0.
    - If sync_q=0: go to LOW and set glitch_o<=1.
    - Else if cnt+1==STABLE_CYCLES: go to HIGH, set data_o<=1, cnt<=0.
    - Else cnt<=cnt+1.
  - HIGH: data_o=1. If sync_q=0, go to FALL_CHK with cnt<=1.
  - FALL_CHK: data_o=1.
    - If sync_q=1: go to HIGH and set glitch_o<=1.
    - Else if cnt+1==STABLE_CYCLES: go to LOW, set data_o<=0, cnt<=0.
    - Else cnt<=cnt+1.
- The entry sample counts as sample 1. data_o flips on the edge that samples the STABLE_CYCLES-th consecutive matching sync_q value.
- Latency: data_i is first captured at edge 1. data_o changes after edge SYNC_STAGES+STABLE_CYCLES.
- busy_o is high for STABLE_CYCLES-1 cycles on a clean transition.
- glitch_o is set by the same edge that returns the FSM to LOW or HIGH. It is high for exactly one cycle, then cleared.
- An abort restarts qualification from scratch: the counter never carries over.
- A new opposite sample on the cycle immediately after an abort re-enters CHK with cnt=1.
- Counter arithmetic is unsigned CNT_W bits and never wraps: it is bounded by STABLE_CYCLES-1.
- data_o never changes outside the two qualifying transitions. It holds through any bounce shorter than STABLE_CYCLES samples.
- Elaboration check: a fatal error if STABLE_CYCLES<2 or SYNC_STAGES<2.

Decomposition:
- Package debounce_pkg holds:
  - the state enum: LOW, RISE_CHK, HIGH, FALL_CHK (2-bit encoding);
  - localparam MIN_STABLE_CYCLES = 2;
  - localparam MIN_SYNC_STAGES = 2.
- One sub-module: sync_cell.
  - Parameterised by SYNC_STAGES.
  - Ports: clk, reset, d_i, q_o.
  - Asynchronous reset to 0.
  - Instanced once; reusable elsewhere in the codebase.
- FSM and counter live in debounce itself.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4 unless stated):
- Clean rise: data_i 0->1 before edge 1, held high -> busy_o high after edges 3,4,5; data_o=1 after edge 6; glitch_o stays 0.
- Short bounce: data_i high only across edges 1-2, then low -> FSM enters RISE_CHK at edge 3, aborts at edge 5; glitch_o=1 for the single cycle after edge 5; data_o stays 0.
- Boundary: data_i high for exactly 3 sampled cycles, then low -> data_o stays 0 and glitch_o pulses; repeat with 4 cycles -> data_o=1 after edge 6 and no glitch_o.
- Fall with bounce: starting from HIGH, data_i alternates 0,1,0,1 then holds 0 -> one glitch_o pulse per abort; data_o drops only after 4 consecutive low samples; no spurious 1->0->1 on data_o.
- Reset mid-qualification: reset asserted asynchronously while in RISE_CHK with cnt=2 -> data_o, busy_o, glitch_o all 0 immediately; after release with data_i high, full SYNC_STAGES+STABLE_CYCLES latency applies again.
- Default parameters (STABLE_CYCLES=1000): 999-cycle high burst -> no data_o change; 1000-cycle burst -> data_o=1 after edge 1002; counter never exceeds 999.
